// File: rtl/mag_timer.sv
// Cook-time countdown and magnetron latch: BCD mm:ss count-down, one tick per CLK_HZ cycles in RUN.
// Optional end-of-cook beep output is built only when MAG_TIMER_BEEP_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | time is 00:00, magnetron off
// S_ARMED | time nonzero, magnetron off (also paused)
// S_RUN   | magnetron on, counting down once per second
// S_DONE  | countdown reached 00:00, timer_done high
module mag_timer #(
    parameter int CLK_HZ    = 100,
    parameter int BEEP_SECS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Set,
    input  logic        Reset,
    input  logic        load,
    input  logic [15:0] time_in,
    input  logic        clear,
    output logic        mag_on,
    output logic        timer_done,
`ifdef MAG_TIMER_BEEP_EN
    output logic        beep,
`endif
    output logic [15:0] time_bcd
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_LOAD = PW'(CLK_HZ - 1);

    if (CLK_HZ < 2 || BEEP_SECS < 1) begin : g_bad_param
        $error("mag_timer: CLK_HZ must be >= 2 and BEEP_SECS >= 1");
    end

    state_t        state, state_nxt;
    logic [15:0]   time_nxt;
    logic [PW-1:0] pre_cnt, pre_nxt;
    logic          tick;

    function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
        logic [3:0] d3, d2, d1, d0;
        d3 = (v[15:12] > 4'd9) ? 4'd9 : v[15:12];
        d2 = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
        d1 = (v[7:4]   > 4'd5) ? 4'd5 : v[7:4];
        d0 = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
        return {d3, d2, d1, d0};
    endfunction

    // Borrow ripples upward; never called with 00:00, so min_tens cannot underflow.
    function automatic logic [15:0] dec_bcd(input logic [15:0] v);
        logic [3:0] d3, d2, d1, d0;
        {d3, d2, d1, d0} = v;
        if (d0 != 4'd0) begin
            d0 = d0 - 4'd1;
        end else begin
            d0 = 4'd9;
            if (d1 != 4'd0) begin
                d1 = d1 - 4'd1;
            end else begin
                d1 = 4'd5;
                if (d2 != 4'd0) begin
                    d2 = d2 - 4'd1;
                end else begin
                    d2 = 4'd9;
                    d3 = d3 - 4'd1;
                end
            end
        end
        return {d3, d2, d1, d0};
    endfunction

    // The prescaler is a down-counter; reloading PRE_LOAD is the "restart at 0" of the second.
    assign tick = (state == S_RUN) && (pre_cnt == '0);

    always_comb begin
        state_nxt = state;
        time_nxt  = time_bcd;
        pre_nxt   = pre_cnt;
        if (clear) begin
            state_nxt = S_IDLE;
            time_nxt  = '0;
            pre_nxt   = PRE_LOAD;
        end else if (Reset && state == S_RUN) begin
            state_nxt = S_ARMED;
            pre_nxt   = PRE_LOAD;
        end else if (load && state != S_RUN) begin
            time_nxt  = clamp_bcd(time_in);
            state_nxt = (clamp_bcd(time_in) != '0) ? S_ARMED : S_IDLE;
            pre_nxt   = PRE_LOAD;
        end else if (Set && !Reset && state == S_ARMED) begin
            state_nxt = S_RUN;
            pre_nxt   = PRE_LOAD;
        end else if (state == S_RUN) begin
            if (tick) begin
                pre_nxt  = PRE_LOAD;
                time_nxt = dec_bcd(time_bcd);
                if (dec_bcd(time_bcd) == '0) begin
                    state_nxt = S_DONE;
                end
            end else begin
                pre_nxt = pre_cnt - PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            time_bcd   <= '0;
            pre_cnt    <= PRE_LOAD;
            mag_on     <= 1'b0;
            timer_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            time_bcd   <= time_nxt;
            pre_cnt    <= pre_nxt;
            mag_on     <= (state_nxt == S_RUN);
            timer_done <= (state_nxt == S_DONE);
        end
    end

`ifdef MAG_TIMER_BEEP_EN
    localparam int BEEP_CYC = BEEP_SECS * CLK_HZ;
    localparam int BW       = (BEEP_CYC > 2) ? $clog2(BEEP_CYC) : 1;

    logic [BW-1:0] beep_cnt;

    // Only DONE can carry a beep, and DONE is left only through load or clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end else if (state_nxt == S_DONE && state != S_DONE) begin
            beep     <= 1'b1;
            beep_cnt <= BW'(BEEP_CYC - 1);
        end else if (clear || load) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end else if (beep) begin
            if (beep_cnt == '0) begin
                beep <= 1'b0;
            end else begin
                beep_cnt <= beep_cnt - BW'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mag_timer.sv
// Bench for mag_timer at CLK_HZ=4, BEEP_SECS=2; reference model tracks remaining seconds as an integer.
// Define MAG_TIMER_BEEP_EN to include the beep checks.
module tb_mag_timer;

    localparam int CLK_HZ    = 4;
    localparam int BEEP_SECS = 2;
`ifdef MAG_TIMER_BEEP_EN
    localparam int BEEP_CYC = BEEP_SECS * CLK_HZ;
`else
    localparam int BEEP_CYC = 0;
`endif
    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Set = 1'b0;
    logic        Reset = 1'b0;
    logic        load = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] time_in = 16'h0000;
    logic        mag_on, timer_done, beep_w;
    logic [15:0] time_bcd;

    int vecs = 0;
    int errs = 0;
    int m_mode = M_IDLE, m_secs = 0, m_phase = 0, m_beep = 0;

    mag_timer #(.CLK_HZ(CLK_HZ), .BEEP_SECS(BEEP_SECS)) dut (
        .clk(clk), .rst(rst), .Set(Set), .Reset(Reset), .load(load),
        .time_in(time_in), .clear(clear), .mag_on(mag_on), .timer_done(timer_done),
`ifdef MAG_TIMER_BEEP_EN
        .beep(beep_w),
`endif
        .time_bcd(time_bcd)
    );
`ifndef MAG_TIMER_BEEP_EN
    assign beep_w = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit expired, vectors=%0d", vecs);
        $fatal(1, "watchdog");
    end

    function automatic int clamp_secs(input logic [15:0] v);
        int d3, d2, d1, d0;
        d3 = int'(v[15:12]); d2 = int'(v[11:8]); d1 = int'(v[7:4]); d0 = int'(v[3:0]);
        if (d3 > 9) d3 = 9;
        if (d2 > 9) d2 = 9;
        if (d1 > 5) d1 = 5;
        if (d0 > 9) d0 = 9;
        return (d3 * 10 + d2) * 60 + d1 * 10 + d0;
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [18:0] exp_vec();
        return {m_mode == M_RUN, m_mode == M_DONE, m_beep > 0, to_bcd(m_secs)};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_secs = 0; m_phase = 0; m_beep = 0;
    endtask

    task automatic model_edge();
        if (m_beep > 0) m_beep--;
        if (clear) begin
            m_mode = M_IDLE; m_secs = 0; m_phase = 0; m_beep = 0;
        end else if (Reset && m_mode == M_RUN) begin
            m_mode = M_ARMED; m_phase = 0;
        end else if (load && m_mode != M_RUN) begin
            m_secs  = clamp_secs(time_in);
            m_mode  = (m_secs != 0) ? M_ARMED : M_IDLE;
            m_phase = 0;
            m_beep  = 0;
        end else if (Set && !Reset && m_mode == M_ARMED) begin
            m_mode = M_RUN; m_phase = 0;
        end else if (m_mode == M_RUN) begin
            m_phase++;
            if (m_phase == CLK_HZ) begin
                m_phase = 0;
                m_secs--;
                if (m_secs == 0) begin
                    m_mode = M_DONE;
                    m_beep = BEEP_CYC;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; time_in = v; cycle(); load = 1'b0;
    endtask
    task automatic do_set();
        Set = 1'b1; cycle(); Set = 1'b0;
    endtask
    task automatic do_clear();
        clear = 1'b1; cycle(); clear = 1'b0;
    endtask
    task automatic do_pause();
        Reset = 1'b1; cycle(); Reset = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        vecs++;
        if ({mag_on, timer_done, beep_w, time_bcd} !== 19'h0) begin
            errs++;
            $display("FAIL reset_async got=%h exp=%h", {mag_on, timer_done, beep_w, time_bcd}, 19'h0);
        end
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        cycle();
        vecs++;
        if ({mag_on, timer_done, beep_w, time_bcd} !== exp_vec()) begin
            errs++;
            $display("FAIL reset_release got=%h exp=%h", {mag_on, timer_done, beep_w, time_bcd}, exp_vec());
        end
    endtask

    task automatic test_basic_run();
        do_load(16'h0003);
        vecs++;
        if (time_bcd !== 16'h0003 || mag_on !== 1'b0) begin
            errs++;
            $display("FAIL basic_load time=%h mag=%b exp time=0003 mag=0", time_bcd, mag_on);
        end
        do_set();
        vecs++;
        if (mag_on !== 1'b1) begin
            errs++;
            $display("FAIL basic_mag_on got=%b exp=1", mag_on);
        end
        for (int i = 1; i <= 12; i++) begin
            cycle();
            vecs++;
            if ({mag_on, timer_done, beep_w, time_bcd} !== exp_vec()) begin
                errs++;
                $display("FAIL basic_model cyc=%0d got=%h exp=%h", i, {mag_on, timer_done, beep_w, time_bcd}, exp_vec());
            end
            if (i == 4 || i == 8) begin
                vecs++;
                if (time_bcd !== ((i == 4) ? 16'h0002 : 16'h0001)) begin
                    errs++;
                    $display("FAIL basic_tick cyc=%0d got=%h", i, time_bcd);
                end
            end
        end
        vecs++;
        if (time_bcd !== 16'h0000 || mag_on !== 1'b0 || timer_done !== 1'b1) begin
            errs++;
            $display("FAIL basic_done time=%h mag=%b done=%b exp 0000/0/1", time_bcd, mag_on, timer_done);
        end
    endtask

    task automatic test_borrow();
        do_clear();
        do_load(16'h1000);
        do_set();
        repeat (4) cycle();
        vecs++;
        if (time_bcd !== 16'h0959 || time_bcd !== to_bcd(m_secs)) begin
            errs++;
            $display("FAIL borrow_1000 got=%h exp=0959", time_bcd);
        end
        do_pause();
        do_load(16'h0100);
        do_set();
        repeat (4) cycle();
        vecs++;
        if (time_bcd !== 16'h0059 || mag_on !== 1'b1) begin
            errs++;
            $display("FAIL borrow_0100 got=%h mag=%b exp=0059 mag=1", time_bcd, mag_on);
        end
        do_pause();
    endtask

    task automatic test_pause_resume();
        do_clear();
        do_load(16'h0007);
        do_set();
        repeat (8) cycle();
        repeat (2) cycle();
        do_pause();
        vecs++;
        if (time_bcd !== 16'h0005 || mag_on !== 1'b0 || timer_done !== 1'b0) begin
            errs++;
            $display("FAIL pause_hold time=%h mag=%b exp=0005 mag=0", time_bcd, mag_on);
        end
        repeat (3) cycle();
        do_set();
        for (int k = 1; k <= 4; k++) begin
            cycle();
            vecs++;
            if (time_bcd !== ((k < 4) ? 16'h0005 : 16'h0004)) begin
                errs++;
                $display("FAIL resume_tick k=%0d got=%h", k, time_bcd);
            end
        end
        repeat (3) cycle();
        do_pause();
        vecs++;
        if (time_bcd !== 16'h0004 || mag_on !== 1'b0 || {mag_on, timer_done, beep_w, time_bcd} !== exp_vec()) begin
            errs++;
            $display("FAIL pause_on_tick got=%h mag=%b exp=0004 mag=0", time_bcd, mag_on);
        end
    endtask

    task automatic test_priority();
        int waited;
        do_clear();
        do_load(16'h0002);
        Set = 1'b1; Reset = 1'b1; cycle(); Set = 1'b0; Reset = 1'b0;
        vecs++;
        if (mag_on !== 1'b0 || time_bcd !== 16'h0002) begin
            errs++;
            $display("FAIL set_with_reset mag=%b time=%h exp mag=0 time=0002", mag_on, time_bcd);
        end
        do_set();
        do_load(16'h0500);
        vecs++;
        if (mag_on !== 1'b1 || time_bcd !== 16'h0002) begin
            errs++;
            $display("FAIL load_in_run mag=%b time=%h exp mag=1 time=0002", mag_on, time_bcd);
        end
        waited = 0;
        while (timer_done !== 1'b1 && waited < 20) begin
            cycle();
            waited++;
        end
        vecs++;
        if (timer_done !== 1'b1 || {mag_on, timer_done, beep_w, time_bcd} !== exp_vec()) begin
            errs++;
            $display("FAIL reach_done after %0d cycles got=%h exp=%h", waited, {mag_on, timer_done, beep_w, time_bcd}, exp_vec());
        end
        do_set();
        vecs++;
        if (mag_on !== 1'b0 || timer_done !== 1'b1) begin
            errs++;
            $display("FAIL set_in_done mag=%b done=%b exp mag=0 done=1", mag_on, timer_done);
        end
        do_clear();
        vecs++;
        if (time_bcd !== 16'h0000 || timer_done !== 1'b0 || mag_on !== 1'b0 || beep_w !== 1'b0) begin
            errs++;
            $display("FAIL clear_in_done time=%h done=%b beep=%b exp 0000/0/0", time_bcd, timer_done, beep_w);
        end
    endtask

    task automatic test_clamp();
        do_load(16'hFFFF);
        vecs++;
        if (time_bcd !== 16'h9959) begin
            errs++;
            $display("FAIL clamp_ffff got=%h exp=9959", time_bcd);
        end
        do_load(16'h1A7F);
        vecs++;
        if (time_bcd !== 16'h1959) begin
            errs++;
            $display("FAIL clamp_1a7f got=%h exp=1959", time_bcd);
        end
        do_load(16'h0000);
        vecs++;
        if ({mag_on, timer_done, time_bcd} !== 18'h0) begin
            errs++;
            $display("FAIL load_zero got=%h exp=00000", {mag_on, timer_done, time_bcd});
        end
        do_set();
        vecs++;
        if (mag_on !== 1'b0 || time_bcd !== 16'h0000) begin
            errs++;
            $display("FAIL set_in_idle mag=%b time=%h exp mag=0 time=0000", mag_on, time_bcd);
        end
    endtask

`ifdef MAG_TIMER_BEEP_EN
    task automatic test_beep();
        int waited, hi;
        do_clear();
        do_load(16'h0001);
        do_set();
        waited = 0;
        while (timer_done !== 1'b1 && waited < 20) begin
            cycle();
            waited++;
        end
        vecs++;
        if (beep_w !== 1'b1 || timer_done !== 1'b1) begin
            errs++;
            $display("FAIL beep_start beep=%b done=%b exp 1/1", beep_w, timer_done);
        end
        hi = 1;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            if (beep_w === 1'b1) hi++;
            vecs++;
            if ({mag_on, timer_done, beep_w, time_bcd} !== exp_vec()) begin
                errs++;
                $display("FAIL beep_model cyc=%0d got=%h exp=%h", i, {mag_on, timer_done, beep_w, time_bcd}, exp_vec());
            end
        end
        vecs++;
        if (hi != 8) begin
            errs++;
            $display("FAIL beep_length got=%0d cycles exp=8", hi);
        end
        do_load(16'h0001);
        do_set();
        waited = 0;
        while (timer_done !== 1'b1 && waited < 20) begin
            cycle();
            waited++;
        end
        repeat (2) cycle();
        vecs++;
        if (beep_w !== 1'b1) begin
            errs++;
            $display("FAIL beep_before_clear got=%b exp=1", beep_w);
        end
        do_clear();
        vecs++;
        if (beep_w !== 1'b0) begin
            errs++;
            $display("FAIL beep_clear got=%b exp=0", beep_w);
        end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            clear = ($urandom_range(0, 49) == 0);
            Reset = ($urandom_range(0, 7) == 0);
            load  = ($urandom_range(0, 11) == 0);
            Set   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) time_in = 16'($urandom);
            else time_in = {12'h000, 4'($urandom_range(0, 15))};
            cycle();
            vecs++;
            if ({mag_on, timer_done, beep_w, time_bcd} !== exp_vec()) begin
                errs++;
                $display("FAIL random n=%0d got=%h exp=%h", n, {mag_on, timer_done, beep_w, time_bcd}, exp_vec());
            end
        end
        clear = 1'b0; Reset = 1'b0; load = 1'b0; Set = 1'b0;
    endtask

    task automatic test_async_reset();
        do_clear();
        do_load(16'h0030);
        do_set();
        repeat (5) cycle();
        vecs++;
        if (mag_on !== 1'b1 || time_bcd !== 16'h0029) begin
            errs++;
            $display("FAIL pre_rst mag=%b time=%h exp mag=1 time=0029", mag_on, time_bcd);
        end
        #2 rst = 1'b1;
        #1;
        vecs++;
        if ({mag_on, timer_done, beep_w, time_bcd} !== 19'h0) begin
            errs++;
            $display("FAIL rst_mid_run got=%h exp=%h", {mag_on, timer_done, beep_w, time_bcd}, 19'h0);
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        do_set();
        vecs++;
        if ({mag_on, timer_done, beep_w, time_bcd} !== exp_vec()) begin
            errs++;
            $display("FAIL after_rst got=%h exp=%h", {mag_on, timer_done, beep_w, time_bcd}, exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_borrow();
        test_pause_resume();
        test_priority();
        test_clamp();
`ifdef MAG_TIMER_BEEP_EN
        test_beep();
`endif
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mag_timer.md
# mag_timer

Cook-time countdown and magnetron latch for the microwave controller. It consumes the `Set`/`Reset` pair produced by the magnetron on/off control and drives `mag_on`. It counts a BCD mm:ss cook time down once per second while the magnetron is on. It returns `timer_done` to the on/off control, closing the loop that switches the magnetron off at 00:00.

## Interface
Parameters:
- `CLK_HZ`, 100, clock cycles per second; 2 or more.
- `BEEP_SECS`, 3, beep duration in seconds; used only with `MAG_TIMER_BEEP_EN`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `Set`  in  1  level; request magnetron on.
- `Reset`  in  1  level; force magnetron off; dominates `Set`.
- `load`  in  1  single-cycle pulse; capture `time_in`.
- `time_in`  in  16  BCD {min_tens, min_ones, sec_tens, sec_ones}.
- `clear`  in  1  level; zero the time and return to IDLE.
- `mag_on`  out  1  registered magnetron enable.
- `timer_done`  out  1  registered; high in DONE.
- `time_bcd`  out  16  current remaining time, same format as `time_in`.
- `beep`  out  1  present only with `MAG_TIMER_BEEP_EN`.

## Operation
- States:
  - IDLE: time 00:00.
  - ARMED: time nonzero, magnetron off. This state also covers paused.
  - RUN: magnetron on, counting.
  - DONE: reached 00:00.
- `mag_on` is 1 only in RUN. `timer_done` is 1 only in DONE.
- Priority within a cycle: `clear` > `Reset` > `load` > `Set` > tick.
- `clear`, from any state: time becomes 00:00, next state IDLE, prescaler becomes 0.
- `Reset` in RUN goes to ARMED with the time held. `Reset` in other states has no effect.
- `load` in IDLE, ARMED or DONE captures the clamped `time_in`.
  - Next state is ARMED if the loaded value is nonzero, otherwise IDLE.
  - `load` is ignored in RUN.
- Clamp rule: any digit above 9 becomes 9. `sec_tens` above 5 becomes 5. Example: 0x1A7F loads as 0x1959.
- `Set` with `Reset` low:
  - In ARMED, go to RUN and clear the prescaler.
  - In IDLE and DONE, `Set` is ignored.
- Prescaler counts 0..CLK_HZ-1 in RUN only. The tick occurs on the wrap from CLK_HZ-1 to 0.
- Tick decrements time in BCD with borrow:
  - `sec_ones` 0 becomes 9 and borrows.
  - `sec_tens` 0 becomes 5 and borrows.
  - `min_ones` 0 becomes 9 and borrows.
  - `min_tens` decrements.
- A tick that produces 00:00 moves to DONE on the same edge; `mag_on` falls on that edge.
- DONE is left only by `load` or `clear`. Holding `timer_done` high keeps the upstream `Reset` asserted, which blocks restart until new time is entered.

## Timing
- Reset values:
  - State IDLE; `time_bcd` 0x0000.
  - `mag_on` 0, `timer_done` 0, `beep` 0.
  - Prescaler 0; beep counter 0.
- All inputs are sampled on the rising `clk`. Every output is registered: an input change appears on the outputs one edge later.
- RUN entry to first tick: exactly CLK_HZ cycles.
- Pausing (`Reset`) loses the partial second; the prescaler restarts at 0 on resume.
- `Reset` and a tick in the same cycle: the tick is discarded and the time is unchanged.
- `rst` asserted mid-RUN: `mag_on` drops immediately (asynchronously) and all state returns to reset values.

## Configuration
- `MAG_TIMER_BEEP_EN` defined:
  - Port `beep` exists.
  - `beep` goes high on the edge that enters DONE and stays high for BEEP_SECS*CLK_HZ cycles, then goes low.
  - `clear`, `load` or `rst` ends the beep immediately.
- `MAG_TIMER_BEEP_EN` undefined: no `beep` port and no beep counter; all other behaviour is identical.

## Test plan
Bench settings: CLK_HZ=4, BEEP_SECS=2.
- Basic run: load 0x0003, then hold `Set` 1 cycle → `mag_on`=1 next edge; `time_bcd` reads 0002/0001/0000 at 4/8/12 cycles; at 0000, `mag_on`=0 and `timer_done`=1 on the same edge.
- Borrow chain: load 0x1000, run 1 tick → 0x0959; load 0x0100, run 1 tick → 0x0059.
- Pause/resume: at 0x0005, pulse `Reset` 2 cycles after a tick → ARMED with 0x0005 held; `Set` → next tick exactly 4 cycles later.
- Priority and ignore cases:
  - `Set`+`Reset` together in ARMED → stays ARMED.
  - `load` during RUN → ignored.
  - `Set` in DONE → `mag_on` stays 0.
  - `clear` in DONE → IDLE, 0x0000, `timer_done`=0.
- Clamp: load 0xFFFF → 0x9959; load 0x0000 → IDLE, and `Set` is ignored.
- Reset and beep: assert `rst` mid-RUN → all outputs 0 without waiting for a clock edge. With `MAG_TIMER_BEEP_EN`: `beep` high for exactly 8 cycles after DONE; `clear` at cycle 3 drops `beep` on the next edge.
